// File: rtl/clock_pkg.sv
// Shared definitions for the period meter: FSM state encoding and default lock depth.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2
  } pm_state_e;

  localparam int LOCK_CNT_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus any-change edge detect.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_edge
);

  logic s_p0;
  logic s_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0    <= 1'b0;
      s_p1    <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      s_p0    <= sig_in;
      s_p1    <= s_p0;
      prev_p2 <= s_p1;
    end
  end

  // Combinational so the FSM registers the result one cycle after s_p1 settles.
  assign sig_edge = s_p1 ^ prev_p2;

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between transitions of an asynchronous divided clock,
// flags lock after repeated equal measurements and times out on a stalled input.
module period_meter
  import clock_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sig_in,
  output logic [BITS-1:0] half_period,
  output logic            valid,
  output logic            locked,
  output logic            timeout
);

  localparam logic [BITS-1:0] CNT_MAX = '1;
  localparam logic [3:0]      LOCK_V  = 4'(LOCK_CNT);

  pm_state_e       state_q, state_n;
  logic [BITS-1:0] cnt_q, cnt_n;
  logic [3:0]      mcnt_q, mcnt_n;
  logic [BITS-1:0] hp_n;
  logic            valid_n, locked_n, timeout_n;
  logic            sig_edge;

  function automatic logic [BITS-1:0] cnt_sat_inc(input logic [BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + BITS'(1);
  endfunction

  function automatic logic [3:0] match_sat_inc(input logic [3:0] v);
    return (v >= LOCK_V) ? LOCK_V : v + 4'd1;
  endfunction

  sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    mcnt_n    = mcnt_q;
    hp_n      = half_period;
    valid_n   = 1'b0;
    timeout_n = 1'b0;
    locked_n  = (mcnt_q == LOCK_V);
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (sig_edge) begin
          state_n = ARM;
          cnt_n   = BITS'(1);
        end
      end
      ARM, TRACK: begin
        // An edge on the saturating cycle wins over the timeout.
        if (sig_edge) begin
          hp_n    = cnt_q;
          valid_n = 1'b1;
          cnt_n   = BITS'(1);
          state_n = TRACK;
          if (state_q == ARM) begin
            mcnt_n = 4'd1;
          end else if (cnt_q == half_period) begin
            mcnt_n = match_sat_inc(mcnt_q);
          end else begin
            mcnt_n   = 4'd1;
            locked_n = 1'b0;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_n = 1'b1;
          locked_n  = 1'b0;
          mcnt_n    = '0;
          cnt_n     = '0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt_sat_inc(cnt_q);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        mcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcnt_q      <= '0;
      half_period <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      mcnt_q      <= mcnt_n;
      half_period <= hp_n;
      valid       <= valid_n;
      locked      <= locked_n;
      timeout     <= timeout_n;
    end
  end

endmodule
